simple_if_to_apb: RTL

- APB initiator bridge: converts simple memory-style write/read requests into APB (psel/penable/pwrite/paddr/pwdata/pstrb) transfers on req_t.
- Collects the APB response (prdata/pready/pslverr) from resp_t and returns a 2-bit status to the requester.
- Sits on the CPU/DMA side of an APB segment, driving APB slaves. It is the counterpart of the existing APB-slave-to-simple-memory bridge.
- One outstanding transfer; no-response timeout protects the requester.

---
 rtl/base_pkg.sv | 37 +++
 rtl/apb_timeout_cnt.sv | 35 +++
 rtl/simple_if_to_apb.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/base_pkg.sv
// Shared APB types for the simple-memory <-> APB bridges: bus structs,
// transfer status codes and the initiator FSM state encoding.
package base_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

  typedef struct packed {
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [APB_ADDR_W-1:0] paddr;
    logic [APB_DATA_W-1:0] pwdata;
    logic [APB_STRB_W-1:0] pstrb;
  } apb_req_t;

  typedef struct packed {
    logic                  pready;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pslverr;
  } apb_resp_t;

  typedef enum logic [1:0] {
    APB_OKAY    = 2'b00,
    APB_SLVERR  = 2'b10,
    APB_TIMEOUT = 2'b11
  } apb_status_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_init_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter; expired_o flags the last permitted ACCESS
// cycle without pready. TIMEOUT = 0 disables expiry.
module apb_timeout_cnt
  import base_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_o = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/simple_if_to_apb.sv
// APB initiator bridge: turns simple-memory write/read requests into single
// APB transfers and returns a one-cycle response pulse with a 2-bit status.
module simple_if_to_apb
  import base_pkg::*;
#(
  parameter type         req_t   = base_pkg::apb_req_t,
  parameter type         resp_t  = base_pkg::apb_resp_t,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  output req_t                req_o,
  input  resp_t               resp_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_waddr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  output logic                mem_wready_o,
  output logic                mem_wvalid_o,
  output logic [1:0]          mem_wresp_o,
  input  logic                mem_re_i,
  input  logic [ADDR_W-1:0]   mem_raddr_i,
  output logic                mem_rready_o,
  output logic                mem_rvalid_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic [1:0]          mem_rresp_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  if (ADDR_W != $bits(req_o.paddr)) begin : g_addr_w_check
    $error("ADDR_W does not match the paddr field of req_t");
  end
  if (DATA_W != $bits(req_o.pwdata)) begin : g_data_w_check
    $error("DATA_W does not match the pwdata field of req_t");
  end
  if ((DATA_W % 8) != 0) begin : g_data_w_bytes
    $error("DATA_W must be a multiple of 8");
  end

  apb_init_state_e     state_q, state_d;
  logic                dir_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                accept;
  logic                done;
  logic                expired;
  apb_status_e         status;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .clr_i     (state_q != ST_ACCESS),
    .en_i      ((state_q == ST_ACCESS) && !resp_i.pready),
    .expired_o (expired)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    done          = 1'b0;
    mem_wready_o  = 1'b0;
    mem_rready_o  = 1'b0;
    mem_wvalid_o  = 1'b0;
    mem_rvalid_o  = 1'b0;
    req_o         = '0;
    req_o.pwrite  = dir_wr_q;
    req_o.paddr   = addr_q;
    req_o.pwdata  = wdata_q;
    req_o.pstrb   = strb_q;

    unique case (state_q)
      ST_IDLE: begin
        // Ready is masked while reset is held so no request looks accepted.
        mem_wready_o = arst_ni & mem_we_i;
        mem_rready_o = arst_ni & mem_re_i & ~mem_we_i;
        accept       = mem_we_i | mem_re_i;
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        req_o.psel = 1'b1;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        req_o.psel    = 1'b1;
        req_o.penable = 1'b1;
        done          = resp_i.pready | expired;
        if (done) state_d = ST_RESP;
      end
      ST_RESP: begin
        mem_wvalid_o = arst_ni & dir_wr_q;
        mem_rvalid_o = arst_ni & ~dir_wr_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if (!resp_i.pready)        status = APB_TIMEOUT;
    else if (resp_i.pslverr)   status = APB_SLVERR;
    else                       status = APB_OKAY;
  end

  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      state_q     <= ST_IDLE;
      dir_wr_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      mem_wresp_o <= '0;
      mem_rresp_o <= '0;
      mem_rdata_o <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dir_wr_q <= mem_we_i;
        addr_q   <= mem_we_i ? mem_waddr_i : mem_raddr_i;
        wdata_q  <= mem_we_i ? mem_wdata_i : '0;
        strb_q   <= mem_we_i ? mem_wstrb_i : '0;
      end
      // Response registers only change on completion of their own direction.
      if (done) begin
        if (dir_wr_q) begin
          mem_wresp_o <= status;
        end else begin
          mem_rresp_o <= status;
          mem_rdata_o <= resp_i.pready ? resp_i.prdata : '0;
        end
      end
    end
  end

endmodule
